// File: rtl/st_timing_adapter_buf.sv
// st_timing_adapter_buf
// Avalon-ST timing adapter for a source with no ready signal. A small
// circular buffer absorbs up to DEPTH beats of sink backpressure; beats that
// arrive while the buffer is full and not draining are dropped and reported
// through a sticky overflow flag and a saturating drop counter.
// The head entry and out_valid are held in registers so that every sink-side
// output comes straight from a flop.

module st_timing_adapter_buf #(
   parameter int DATA_W     = 8,
   parameter int CHAN_W     = 1,
   parameter int DEPTH      = 4,
   parameter int DROP_CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   input  logic [CHAN_W-1:0]          in_channel,
   input  logic                       in_startofpacket,
   input  logic                       in_endofpacket,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic [CHAN_W-1:0]          out_channel,
   output logic                       out_startofpacket,
   output logic                       out_endofpacket,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] fill_level,
   output logic                       overflow,
   input  logic                       overflow_clear,
   output logic [DROP_CNT_W-1:0]      drop_count
);

   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int ENTRY_W = DATA_W + CHAN_W + 2;

   localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0]      PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0]      PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};
   localparam logic [DROP_CNT_W-1:0] DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [DROP_CNT_W-1:0] DROP_ZERO = {DROP_CNT_W{1'b0}};

   // Entry layout: {data, channel, sop, eop}; all fields always travel together.
   logic [ENTRY_W-1:0] mem_r [DEPTH];

   logic [PTR_W-1:0]      rd_ptr_r;
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic                  out_valid_r;
   logic [ENTRY_W-1:0]    head_r;
   logic                  overflow_r;
   logic [DROP_CNT_W-1:0] drop_count_r;

   logic                  pop_s;
   logic                  push_s;
   logic                  drop_s;
   logic                  full_s;
   logic [CNT_W-1:0]      count_next_s;
   logic [CNT_W-1:0]      remain_s;
   logic [PTR_W-1:0]      rd_next_s;
   logic [PTR_W-1:0]      wr_next_s;
   logic                  head_from_in_s;
   logic [ENTRY_W-1:0]    in_entry_s;
   logic [ENTRY_W-1:0]    head_next_s;

   // Handshake decode: pop frees a slot in the same cycle, so a full buffer
   // that is also draining still accepts the incoming beat.
   always_comb begin
      in_entry_s = {in_data, in_channel, in_startofpacket, in_endofpacket};
      full_s     = (count_r == DEPTH_C);
      pop_s      = out_valid_r & out_ready;
      push_s     = in_valid & (~full_s | pop_s);
      drop_s     = in_valid & full_s & ~pop_s;
   end

   // Next-state arithmetic for pointers and occupancy; pointers wrap naturally
   // because DEPTH is a power of two.
   always_comb begin
      rd_next_s    = rd_ptr_r;
      wr_next_s    = wr_ptr_r;
      count_next_s = count_r;
      if (pop_s) begin
         rd_next_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_next_s = rd_ptr_r;
      end
      if (push_s) begin
         wr_next_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_next_s = wr_ptr_r;
      end
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CNT_ONE;
         2'b01:   count_next_s = count_r - CNT_ONE;
         default: count_next_s = count_r;
      endcase
   end

   // Head selection: when nothing older survives this edge, the beat being
   // written now becomes the new head; otherwise read the next stored entry.
   always_comb begin
      remain_s       = count_r - (pop_s ? CNT_ONE : CNT_ZERO);
      head_from_in_s = push_s & (remain_s == CNT_ZERO);
      if (head_from_in_s) begin
         head_next_s = in_entry_s;
      end else begin
         head_next_s = mem_r[rd_next_s];
      end
   end

   // Storage array: written on push only; contents survive reset but are
   // unreachable afterwards because the pointers are reset.
   always_ff @(posedge clk) begin
      if (push_s && !reset) begin
         mem_r[wr_ptr_r] <= in_entry_s;
      end
   end

   // Pointer, occupancy and registered head/valid state.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_r    <= PTR_ZERO;
         wr_ptr_r    <= PTR_ZERO;
         count_r     <= CNT_ZERO;
         out_valid_r <= 1'b0;
         head_r      <= {ENTRY_W{1'b0}};
      end else begin
         rd_ptr_r    <= rd_next_s;
         wr_ptr_r    <= wr_next_s;
         count_r     <= count_next_s;
         out_valid_r <= (count_next_s != CNT_ZERO);
         head_r      <= head_next_s;
      end
   end

   // Overflow reporting: a drop in the same cycle as a clear wins, leaving
   // the flag set and the counter at one.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_r   <= 1'b0;
         drop_count_r <= DROP_ZERO;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
         if (overflow_clear) begin
            drop_count_r <= DROP_ONE;
         end else if (drop_count_r == DROP_MAX) begin
            drop_count_r <= DROP_MAX;
         end else begin
            drop_count_r <= drop_count_r + DROP_ONE;
         end
      end else if (overflow_clear) begin
         overflow_r   <= 1'b0;
         drop_count_r <= DROP_ZERO;
      end else begin
         overflow_r   <= overflow_r;
         drop_count_r <= drop_count_r;
      end
   end

   assign out_valid         = out_valid_r;
   assign out_data          = head_r[ENTRY_W-1 -: DATA_W];
   assign out_channel       = head_r[CHAN_W+1 -: CHAN_W];
   assign out_startofpacket = head_r[1];
   assign out_endofpacket   = head_r[0];
   assign fill_level        = count_r;
   assign overflow          = overflow_r;
   assign drop_count        = drop_count_r;

endmodule
